// File: rtl/l1_mem_arb_pkg.sv
// Shared types and project constants for the L1 I$/D$ memory-port arbiter.
package l1_mem_arb_pkg;

  localparam int unsigned PC_SZ          = 32;
  localparam int unsigned CL_LEN         = 16;
  localparam int unsigned L1_ARB_TIMEOUT = 255;

  typedef enum logic [1:0] {
    IDLE,
    IC_BUSY,
    DC_BUSY,
    RESP
  } arb_state_t;

  typedef enum logic {
    GNT_IC,
    GNT_DC
  } grant_type_t;

endpackage

// File: rtl/l1_mem_arb_if.sv
// Request/ack bundle between the L1 caches, the arbiter and the memory port.
interface l1_mem_arb_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 128
);

  logic          ic_req;
  logic [AW-1:0] ic_addr;
  logic          ic_ack;
  logic [DW-1:0] ic_ack_data;
  logic          ic_ack_fault;

  logic          dc_req;
  logic          dc_wr;
  logic [AW-1:0] dc_addr;
  logic [DW-1:0] dc_wr_data;
  logic          dc_ack;
  logic [DW-1:0] dc_ack_data;
  logic          dc_ack_fault;

  logic          mem_req;
  logic          mem_wr;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wr_data;
  logic          mem_ack;
  logic [DW-1:0] mem_ack_data;
  logic          mem_ack_fault;

  // Arbiter side
  modport slave (
    input  ic_req, ic_addr, dc_req, dc_wr, dc_addr, dc_wr_data,
           mem_ack, mem_ack_data, mem_ack_fault,
    output ic_ack, ic_ack_data, ic_ack_fault, dc_ack, dc_ack_data, dc_ack_fault,
           mem_req, mem_wr, mem_addr, mem_wr_data
  );

  // Cache/memory side
  modport master (
    output ic_req, ic_addr, dc_req, dc_wr, dc_addr, dc_wr_data,
           mem_ack, mem_ack_data, mem_ack_fault,
    input  ic_ack, ic_ack_data, ic_ack_fault, dc_ack, dc_ack_data, dc_ack_fault,
           mem_req, mem_wr, mem_addr, mem_wr_data
  );

endinterface

// File: rtl/l1_mem_arb_watchdog.sv
// Loadable saturating up-counter; expired is high once the count reaches TIMEOUT.
module l1_mem_arb_watchdog
  import l1_mem_arb_pkg::*;
#(
  parameter  int unsigned TIMEOUT = L1_ARB_TIMEOUT,
  localparam int unsigned TW      = $clog2(TIMEOUT + 1)
) (
  input  logic          clk_in,
  input  logic          reset_in,
  input  logic          clr,
  input  logic          en,
  input  logic          load,
  input  logic [TW-1:0] load_val,
  output logic          expired
);

  logic [TW-1:0] count;

  assign expired = (count == TW'(TIMEOUT));

  always_ff @(posedge clk_in) begin
    if (!reset_in || clr) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && !expired) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/l1_mem_arb.sv
// One-outstanding-transaction arbiter between L1 I$ and D$ miss paths and a shared memory port.
// Define L1_ARB_DC_PRIORITY_EN for fixed D$ priority instead of round-robin.
module l1_mem_arb
  import l1_mem_arb_pkg::*;
#(
  parameter int unsigned AW      = PC_SZ,
  parameter int unsigned DW      = CL_LEN * 8,
  parameter int unsigned TIMEOUT = L1_ARB_TIMEOUT
) (
  input logic        clk_in,
  input logic        reset_in,
  l1_mem_arb_if.slave bus
);

  arb_state_t    state, state_nxt;
  grant_type_t   last_grant, gnt_sel;
  logic          grant, done, timed_out, wd_expired, busy;
  logic          sel_wr;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wr_data;

  assign busy = (state == IC_BUSY) || (state == DC_BUSY);

  l1_mem_arb_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk_in   (clk_in),
    .reset_in (reset_in),
    .clr      (grant),
    .en       (busy),
    .load     (1'b0),
    .load_val ('0),
    .expired  (wd_expired)
  );

  always_ff @(posedge clk_in) begin
    if (!reset_in) state <= IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    gnt_sel   = GNT_IC;
    done      = 1'b0;
    timed_out = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.ic_req && bus.dc_req) begin
          grant = 1'b1;
`ifdef L1_ARB_DC_PRIORITY_EN
          gnt_sel = GNT_DC;
`else
          gnt_sel = (last_grant == GNT_DC) ? GNT_IC : GNT_DC;
`endif
        end else if (bus.ic_req) begin
          grant   = 1'b1;
          gnt_sel = GNT_IC;
        end else if (bus.dc_req) begin
          grant   = 1'b1;
          gnt_sel = GNT_DC;
        end
        if (grant) state_nxt = (gnt_sel == GNT_IC) ? IC_BUSY : DC_BUSY;
      end
      IC_BUSY, DC_BUSY: begin
        // A real completion on the expiry cycle takes precedence over the forced fault.
        if (bus.mem_ack) begin
          done = 1'b1;
        end else if (wd_expired) begin
          done      = 1'b1;
          timed_out = 1'b1;
        end
        if (done) state_nxt = RESP;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign sel_addr    = (gnt_sel == GNT_DC) ? bus.dc_addr : bus.ic_addr;
  assign sel_wr      = (gnt_sel == GNT_DC) && bus.dc_wr;
  assign sel_wr_data = (gnt_sel == GNT_DC) ? bus.dc_wr_data : '0;

  always_ff @(posedge clk_in) begin
    if (!reset_in) begin
      bus.mem_req      <= 1'b0;
      bus.mem_wr       <= 1'b0;
      bus.mem_addr     <= '0;
      bus.mem_wr_data  <= '0;
      bus.ic_ack       <= 1'b0;
      bus.ic_ack_data  <= '0;
      bus.ic_ack_fault <= 1'b0;
      bus.dc_ack       <= 1'b0;
      bus.dc_ack_data  <= '0;
      bus.dc_ack_fault <= 1'b0;
      last_grant       <= GNT_DC;
    end else begin
      bus.ic_ack <= 1'b0;
      bus.dc_ack <= 1'b0;
      if (grant) begin
        bus.mem_req     <= 1'b1;
        bus.mem_wr      <= sel_wr;
        bus.mem_addr    <= sel_addr;
        bus.mem_wr_data <= sel_wr_data;
        last_grant      <= gnt_sel;
      end
      if (done) begin
        bus.mem_req <= 1'b0;
        if (state == IC_BUSY) begin
          bus.ic_ack       <= 1'b1;
          bus.ic_ack_data  <= timed_out ? '0 : bus.mem_ack_data;
          bus.ic_ack_fault <= timed_out ? 1'b1 : bus.mem_ack_fault;
        end else begin
          bus.dc_ack       <= 1'b1;
          bus.dc_ack_data  <= timed_out ? '0 : bus.mem_ack_data;
          bus.dc_ack_fault <= timed_out ? 1'b1 : bus.mem_ack_fault;
        end
      end
    end
  end

endmodule

// File: doc/l1_mem_arb.md
Name: l1_mem_arb

Overview:
- Arbitrates one shared cache-line memory port between the L1 instruction cache miss path and the L1 data cache miss/write-back path.
- Sits between the L1IC/L1DC slave-side caches and the external memory/L2 interface.
- Sequences one outstanding transaction at a time and routes the returned data and fault to the granted requester.
- A watchdog converts a hung memory transaction into a faulted acknowledge.

Parameters:
- AW, 32 (PC_SZ): address width.
- DW, 128 (CL_LEN*8): cache-line data width.
- TIMEOUT, 255: cycles to wait for mem_ack before forcing a fault; must be ≥ 1.
- TW, $clog2(TIMEOUT+1): watchdog counter width (derived, not overridable).

Ports:
- clk_in  input  1  system clock
- reset_in  input  1  synchronous, active-low reset
- ic_req  input  1  I$ line-fill request; level, held until ic_ack
- ic_addr  input  AW  I$ line address
- ic_ack  output  1  one-cycle acknowledge to I$
- ic_ack_data  output  DW  line data to I$
- ic_ack_fault  output  1  I$ access fault, valid with ic_ack
- dc_req  input  1  D$ request; level, held until dc_ack
- dc_wr  input  1  1 = line write-back, 0 = line fill
- dc_addr  input  AW  D$ line address
- dc_wr_data  input  DW  write-back data
- dc_ack  output  1  one-cycle acknowledge to D$
- dc_ack_data  output  DW  line data to D$ (don't-care on writes)
- dc_ack_fault  output  1  D$ access fault, valid with dc_ack
- mem_req  output  1  memory request; held until mem_ack or timeout
- mem_wr  output  1  write strobe
- mem_addr  output  AW  memory address
- mem_wr_data  output  DW  write data
- mem_ack  input  1  memory completion pulse
- mem_ack_data  input  DW  read data, valid with mem_ack
- mem_ack_fault  input  1  memory error, valid with mem_ack

Behaviour:
- Reset (reset_in = 0 at a clk_in edge) clears all outputs, data buses included, to 0.
- Reset clears state to IDLE, the watchdog count to 0, and last_grant to DC, so the first tie goes to IC.
- Reset mid-transaction abandons the transaction; no ack is issued.

States: IDLE, IC_BUSY, DC_BUSY, RESP.
- IDLE:
  - A single requester asserting its req is granted.
  - If both assert, round-robin picks the one not equal to last_grant.
  - On grant, register the address/wr/data into the mem_* outputs, assert mem_req next cycle, set last_grant, clear the watchdog, and go to IC_BUSY or DC_BUSY.
  - No requests: stay in IDLE.
- IC_BUSY / DC_BUSY:
  - mem_req, mem_wr, mem_addr and mem_wr_data are held stable.
  - Watchdog increments each cycle.
  - On mem_ack: drop mem_req, capture mem_ack_data and mem_ack_fault into the granted requester's ack_data/ack_fault, pulse its ack for one cycle, and go to RESP.
  - On watchdog == TIMEOUT without mem_ack: same exit with ack_fault = 1, ack_data = 0 and mem_req dropped.
  - mem_ack in the same cycle as the timeout wins over the timeout (real data, real fault).
- RESP: one dead cycle, then back to IDLE.
  - The requester samples ack and must drop req, so a stale req is never re-granted.
  - Arbitration resumes the cycle after RESP.
- Latencies:
  - Request to mem_req: 1 cycle.
  - mem_ack to requester ack: 1 cycle (registered).
  - Minimum back-to-back grant spacing: 3 cycles after the ack.
- mem_ack seen while in IDLE or RESP is ignored.
- Exactly one of ic_ack and dc_ack can be high in any cycle.
- Fairness: with both requesters continuously asserting, grants strictly alternate.

Optional Feature:
- Macro L1_ARB_DC_PRIORITY_EN.
- Defined: fixed priority. When both request in IDLE, DC is always granted; IC waits. last_grant is still maintained but unused.
- Undefined: round-robin as above.

Decomposition:
- Shared package cpu_params_pkg / cpu_structs_pkg holds:
  - the ARB_STATE enum {IDLE, IC_BUSY, DC_BUSY, RESP};
  - a GRANT_TYPE enum {GNT_IC, GNT_DC};
  - L1_ARB_TIMEOUT as a project constant.
- Optional sub-module arb_watchdog: loadable up-counter with clear, enable and an expired output, parameterised by TIMEOUT.
- The top level can be wrapped to the L1IC/L1DC interface slave modports in the core.

Test Plan:
- IC only: ic_req = 1, ic_addr = 0x0000_1000, mem_ack 5 cycles after mem_req with data 0xDEAD…BEEF.
  - Required: mem_addr = 0x1000 and mem_wr = 0.
  - One-cycle ic_ack with that data and fault 0.
  - dc_ack never asserts.
- Simultaneous requests after reset: ic_req = dc_req = 1 held.
  - Required: IC granted first, then DC, then IC, strictly alternating.
  - With L1_ARB_DC_PRIORITY_EN defined: DC is granted each time both request.
- DC write-back: dc_wr = 1, dc_addr = 0x2000_0040, dc_wr_data = 0x0123…CDEF.
  - Required: mem_wr = 1 with matching address and data, held stable until mem_ack.
  - One-cycle dc_ack.
- Timeout with TIMEOUT = 8: grant IC and never assert mem_ack.
  - Required: ic_ack and ic_ack_fault = 1 exactly 9 cycles after mem_req rises, ic_ack_data = 0, mem_req low.
  - A late mem_ack in IDLE is ignored.
- Fault passthrough and boundary: mem_ack with mem_ack_fault = 1 → dc_ack_fault = 1.
  - Repeat with mem_ack on the exact timeout cycle: the real data is returned, not the forced fault.
- Reset mid-transaction: reset_in = 0 while in DC_BUSY.
  - Required: next cycle all outputs are 0 and state is IDLE; no ack is issued.
  - After release, a pending ic_req is granted first.
